// File: rtl/cppf_qpll_lock_monitor_pkg.sv
// rtl/cppf_qpll_lock_monitor_pkg.sv - shared types and sizing helpers for the QPLL lock monitor
package cppf_qpll_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED,
        ST_REFCLK_WAIT,
        ST_FAILED
    } qpll_mon_state_t;

    localparam int LOSS_CNT_W = 8;

    // One timer serves every state, so it must reach the longest interval minus one.
    function automatic int timer_width(input int reset_cycles, input int timeout_cycles,
                                       input int stable_cycles);
        int m;
        m = reset_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        if (stable_cycles > m) m = stable_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cppf_qpll_lock_monitor_if.sv
// rtl/cppf_qpll_lock_monitor_if.sv - QPLL wrapper / monitor signal bundle
interface cppf_qpll_lock_monitor_if #(
    parameter int NQUAD = 3
);
    logic [NQUAD-1:0]                          qpll_lock;
    logic [NQUAD-1:0]                          qpll_refclklost;
    logic [NQUAD-1:0]                          qpll_force_reset;
    logic                                      cnt_clear;
    logic [NQUAD-1:0]                          qpll_reset;
    logic [NQUAD-1:0]                          qpll_ready;
    logic                                      all_ready;
    logic [NQUAD-1:0]                          qpll_fail;
    logic [cppf_qpll_pkg::LOSS_CNT_W*NQUAD-1:0] lock_loss_cnt;

    modport master (
        output qpll_lock, qpll_refclklost, qpll_force_reset, cnt_clear,
        input  qpll_reset, qpll_ready, all_ready, qpll_fail, lock_loss_cnt
    );

    modport slave (
        input  qpll_lock, qpll_refclklost, qpll_force_reset, cnt_clear,
        output qpll_reset, qpll_ready, all_ready, qpll_fail, lock_loss_cnt
    );
endinterface

// File: rtl/cppf_qpll_lock_fsm.sv
// rtl/cppf_qpll_lock_fsm.sv - one quad: synchronizers, reset/lock FSM, retry and loss counter
// Loss counter present only when CPPF_QPLL_LOSS_CNT_EN is defined.
module cppf_qpll_lock_fsm
    import cppf_qpll_pkg::*;
#(
    parameter int RESET_CYCLES        = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 40000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRY           = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lock_i,
    input  logic                  refclklost_i,
    input  logic                  force_reset_i,
    input  logic                  cnt_clear_i,
    output logic                  qpll_reset_o,
    output logic                  qpll_ready_o,
    output logic                  qpll_fail_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);
    localparam int TW = timer_width(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] RST_LAST    = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    logic [1:0]      lock_sync_q, lost_sync_q;
    logic            lock_s, lost_s;
    qpll_mon_state_t state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            loss_event;
    logic            reset_q, ready_q, fail_q;

    assign lock_s = lock_sync_q[1];
    assign lost_s = lost_sync_q[1];

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_sync_q <= '0;
            lost_sync_q <= '0;
            state_q     <= ST_RESET;
            timer_q     <= '0;
            retry_q     <= '0;
            reset_q     <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], lock_i};
            lost_sync_q <= {lost_sync_q[0], refclklost_i};
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            reset_q     <= (state_d == ST_RESET) || (state_d == ST_REFCLK_WAIT);
            ready_q     <= (state_d == ST_LOCKED);
            fail_q      <= (state_d == ST_FAILED);
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        loss_event = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lost_s) begin
                    state_d = ST_REFCLK_WAIT;
                    timer_d = '0;
                end else if (lock_s) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_d == RETRY_MAX) ? ST_FAILED : ST_RESET;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // A lock glitch restarts qualification without re-resetting the PLL.
                if (lost_s) begin
                    state_d = ST_REFCLK_WAIT;
                    timer_d = '0;
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (lost_s || !lock_s) begin
                    loss_event = 1'b1;
                    state_d    = lost_s ? ST_REFCLK_WAIT : ST_RESET;
                    timer_d    = '0;
                end
            end
            ST_REFCLK_WAIT: begin
                if (!lost_s) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
            end
            ST_FAILED: begin
                state_d = ST_FAILED;
            end
            default: begin
                state_d = ST_RESET;
                timer_d = '0;
            end
        endcase
        if (force_reset_i) begin
            state_d = ST_RESET;
            timer_d = '0;
            retry_d = '0;
        end
    end

    assign qpll_reset_o = reset_q;
    assign qpll_ready_o = ready_q;
    assign qpll_fail_o  = fail_q;

`ifdef CPPF_QPLL_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (cnt_clear_i) begin
            loss_cnt_d = '0;
        end else if (loss_event && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = cnt_clear_i ^ loss_event;
    assign loss_cnt_o = '0;
`endif

endmodule

// File: rtl/cppf_qpll_lock_monitor.sv
// rtl/cppf_qpll_lock_monitor.sv - per-quad QPLL reset/lock supervisor with aggregate ready
// Loss counters are built only when CPPF_QPLL_LOSS_CNT_EN is defined.
module cppf_qpll_lock_monitor
    import cppf_qpll_pkg::*;
#(
    parameter int NQUAD               = 3,
    parameter int RESET_CYCLES        = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 40000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRY           = 7
) (
    input  logic                     sysclk_in_i,
    input  logic                     soft_reset_n,
    cppf_qpll_lock_monitor_if.slave  mon_if
);
    logic [NQUAD-1:0]            reset_w, ready_w, fail_w;
    logic [LOSS_CNT_W*NQUAD-1:0] cnt_w;
    logic                        all_ready_q;

    for (genvar q = 0; q < NQUAD; q++) begin : g_quad
        cppf_qpll_lock_fsm #(
            .RESET_CYCLES        (RESET_CYCLES),
            .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
            .STABLE_CYCLES       (STABLE_CYCLES),
            .MAX_RETRY           (MAX_RETRY)
        ) u_fsm (
            .clk_i         (sysclk_in_i),
            .rst_ni        (soft_reset_n),
            .lock_i        (mon_if.qpll_lock[q]),
            .refclklost_i  (mon_if.qpll_refclklost[q]),
            .force_reset_i (mon_if.qpll_force_reset[q]),
            .cnt_clear_i   (mon_if.cnt_clear),
            .qpll_reset_o  (reset_w[q]),
            .qpll_ready_o  (ready_w[q]),
            .qpll_fail_o   (fail_w[q]),
            .loss_cnt_o    (cnt_w[LOSS_CNT_W*q +: LOSS_CNT_W])
        );
    end

    // Registered from the per-quad ready flops, hence one cycle behind them.
    always_ff @(posedge sysclk_in_i) begin
        if (!soft_reset_n) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= &ready_w;
        end
    end

    assign mon_if.qpll_reset    = reset_w;
    assign mon_if.qpll_ready    = ready_w;
    assign mon_if.qpll_fail     = fail_w;
    assign mon_if.lock_loss_cnt = cnt_w;
    assign mon_if.all_ready     = all_ready_q;

endmodule

// File: tb/tb_cppf_qpll_lock_monitor.sv
// tb/tb_cppf_qpll_lock_monitor.sv - scoreboard bench for cppf_qpll_lock_monitor
module tb_cppf_qpll_lock_monitor;

    localparam int NQ = 3;
    localparam int RC = 8;
    localparam int TO = 100;
    localparam int SC = 16;
    localparam int MR = 7;

    localparam int F_RST  = 0;
    localparam int F_RDY  = 1;
    localparam int F_FAIL = 2;
    localparam int F_ALL  = 3;
    localparam int F_CNT  = 4;

    typedef struct {
        int    cyc;
        int    fld;
        int    quad;
        int    val;
        string name;
    } exp_t;

    logic  clk;
    logic  resetn;
    int    cyc;
    int    checks;
    int    errors;
    exp_t  exp_q[$];

    cppf_qpll_lock_monitor_if #(.NQUAD(NQ)) bus ();

    cppf_qpll_lock_monitor #(
        .NQUAD               (NQ),
        .RESET_CYCLES        (RC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .STABLE_CYCLES       (SC),
        .MAX_RETRY           (MR)
    ) dut (
        .sysclk_in_i  (clk),
        .soft_reset_n (resetn),
        .mon_if       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cnt_exp(input int v);
`ifdef CPPF_QPLL_LOSS_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int sample(input int fld, input int quad);
        case (fld)
            F_RST:   return (quad < 0) ? int'(bus.qpll_reset) : int'(bus.qpll_reset[quad]);
            F_RDY:   return (quad < 0) ? int'(bus.qpll_ready) : int'(bus.qpll_ready[quad]);
            F_FAIL:  return (quad < 0) ? int'(bus.qpll_fail)  : int'(bus.qpll_fail[quad]);
            F_ALL:   return int'(bus.all_ready);
            default: return (quad < 0) ? int'(bus.lock_loss_cnt) : int'(bus.lock_loss_cnt[8*quad +: 8]);
        endcase
    endfunction

    task automatic expect_at(input int c, input int fld, input int quad, input int val, input string name);
        exp_t e;
        e.cyc = c; e.fld = fld; e.quad = quad; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        if (cyc > c) begin
            errors++;
            $display("FAIL wait_cyc target=%0d already passed at cyc=%0d", c, cyc);
        end else begin
            while (cyc != c) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: compares every due expectation against the bus away from the active edge.
    always @(negedge clk) begin
        int got;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                got = sample(exp_q[i].fld, exp_q[i].quad);
                checks++;
                if (exp_q[i].cyc < cyc || got != exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d(due %0d) got=%0d expected=%0d",
                             exp_q[i].name, cyc, exp_q[i].cyc, got, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, f, g, e, e3, m;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.qpll_lock        = '0;
        bus.qpll_refclklost  = '0;
        bus.qpll_force_reset = '0;
        bus.cnt_clear        = 1'b0;

        expect_at(2, F_RST,  -1, 7, "reset_state_rst");
        expect_at(2, F_RDY,  -1, 0, "reset_state_rdy");
        expect_at(2, F_FAIL, -1, 0, "reset_state_fail");
        expect_at(2, F_ALL,  -1, 0, "reset_state_all");
        expect_at(2, F_CNT,  -1, 0, "reset_state_cnt");

        repeat (3) @(posedge clk);
        #1;
        d = cyc;
        resetn = 1'b1;
        expect_at(d + 7, F_RST, -1, 7, "rst_pulse_last");
        expect_at(d + 8, F_RST, -1, 0, "rst_pulse_end");

        // Quad 1 never locks: timeout every TO+RC cycles, FAILED after MR timeouts.
        expect_at(d + 107, F_RST, 1, 0, "q1_wait_before_to");
        expect_at(d + 108, F_RST, 1, 1, "q1_timeout1_rst");
        expect_at(d + 115, F_RST, 1, 1, "q1_timeout1_hold");
        expect_at(d + 116, F_RST, 1, 0, "q1_timeout1_rel");
        expect_at(d + 648, F_RST, 1, 1, "q1_timeout6_rst");
        expect_at(d + 755, F_FAIL, 1, 0, "q1_not_failed_yet");
        expect_at(d + 756, F_FAIL, 1, 1, "q1_failed");
        expect_at(d + 756, F_RST, 1, 0, "q1_failed_rst_low");
        expect_at(d + 790, F_FAIL, 1, 1, "q1_failed_sticky");
        expect_at(d + 790, F_RST, 1, 0, "q1_failed_rst_sticky");

        // Quads 0 and 2 lock at d+100; quad 2 chatters once during STABLE.
        wait_cyc(d + 100);
        bus.qpll_lock = 3'b101;
        expect_at(d + 118, F_RDY, 0, 0, "q0_ready_early");
        expect_at(d + 119, F_RDY, 0, 1, "q0_ready_rise");
        expect_at(d + 119, F_RDY, 2, 0, "q2_chatter_restart");
        wait_cyc(d + 110);
        bus.qpll_lock[2] = 1'b0;
        wait_cyc(d + 111);
        bus.qpll_lock[2] = 1'b1;
        expect_at(d + 113, F_RST, 2, 0, "q2_chatter_no_rst");
        expect_at(d + 114, F_RST, 2, 0, "q2_chatter_no_rst2");
        expect_at(d + 129, F_RDY, 2, 0, "q2_ready_early");
        expect_at(d + 130, F_RDY, 2, 1, "q2_ready_rise");

        // Quad 2 refclk loss while LOCKED.
        e3 = d + 200;
        wait_cyc(e3);
        bus.qpll_refclklost[2] = 1'b1;
        expect_at(e3 + 2, F_RST, 2, 0, "q2_lost_latency");
        expect_at(e3 + 3, F_RST, 2, 1, "q2_lost_rst");
        expect_at(e3 + 3, F_RDY, 2, 0, "q2_lost_ready_drop");
        expect_at(e3 + 4, F_CNT, 2, cnt_exp(1), "q2_loss_cnt");
        expect_at(e3 + 100, F_RST, 2, 1, "q2_lost_rst_mid");
        wait_cyc(e3 + 200);
        bus.qpll_refclklost[2] = 1'b0;
        expect_at(e3 + 210, F_RST, 2, 1, "q2_post_lost_rst");
        expect_at(e3 + 211, F_RST, 2, 0, "q2_post_lost_rel");
        expect_at(e3 + 227, F_RDY, 2, 0, "q2_relock_early");
        expect_at(e3 + 228, F_RDY, 2, 1, "q2_relock");
        expect_at(e3 + 228, F_ALL, -1, 0, "all_not_ready_q1");

        // Software restart of failed quad 1, now with lock present.
        f = d + 800;
        wait_cyc(f);
        bus.qpll_force_reset[1] = 1'b1;
        bus.qpll_lock[1]        = 1'b1;
        wait_cyc(f + 1);
        bus.qpll_force_reset[1] = 1'b0;
        expect_at(f + 1, F_RST, 1, 1, "q1_force_rst");
        expect_at(f + 1, F_FAIL, 1, 0, "q1_force_fail_clr");
        expect_at(f + 8, F_RST, 1, 1, "q1_force_rst_hold");
        expect_at(f + 9, F_RST, 1, 0, "q1_force_rst_rel");
        expect_at(f + 25, F_RDY, 1, 0, "q1_ready_early");
        expect_at(f + 26, F_RDY, 1, 1, "q1_ready");
        expect_at(f + 26, F_ALL, -1, 0, "all_ready_lag");
        expect_at(f + 27, F_ALL, -1, 1, "all_ready_rise");

        // Quad 0: 300 one-cycle lock drops while LOCKED, saturating at 255.
        g = d + 900;
        for (int k = 1; k <= 300; k++) begin
            e = g + (k - 1) * 30;
            wait_cyc(e);
            bus.qpll_lock[0] = 1'b0;
            if (k == 1) begin
                expect_at(e + 2, F_RDY, 0, 1, "q0_drop_latency");
                expect_at(e + 3, F_RDY, 0, 0, "q0_drop_ready_fall");
                expect_at(e + 3, F_RST, 0, 1, "q0_drop_rst");
                expect_at(e + 4, F_ALL, -1, 0, "all_ready_fall");
                expect_at(e + 27, F_RDY, 0, 0, "q0_relock_early");
                expect_at(e + 28, F_RDY, 0, 1, "q0_relock");
                expect_at(e + 29, F_ALL, -1, 1, "all_ready_back");
            end
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
                expect_at(e + 3, F_CNT, 0, cnt_exp((k > 255) ? 255 : k), $sformatf("q0_cnt_after_%0d", k));
            wait_cyc(e + 1);
            bus.qpll_lock[0] = 1'b1;
        end

        // cnt_clear coinciding with a counted loss.
        e = g + 300 * 30;
        wait_cyc(e);
        bus.qpll_lock[0] = 1'b0;
        expect_at(e + 2, F_CNT, 0, cnt_exp(255), "q0_cnt_before_clr");
        expect_at(e + 3, F_CNT, 0, 0, "q0_cnt_clr_wins");
        expect_at(e + 3, F_CNT, 2, 0, "q2_cnt_cleared");
        wait_cyc(e + 1);
        bus.qpll_lock[0] = 1'b1;
        wait_cyc(e + 2);
        bus.cnt_clear = 1'b1;
        wait_cyc(e + 3);
        bus.cnt_clear = 1'b0;

        e = g + 301 * 30;
        wait_cyc(e);
        bus.qpll_lock[0] = 1'b0;
        expect_at(e + 3, F_CNT, 0, cnt_exp(1), "q0_cnt_after_clr");
        wait_cyc(e + 1);
        bus.qpll_lock[0] = 1'b1;

        // Reset mid-operation.
        m = e + 40;
        expect_at(m, F_RDY, -1, 7, "pre_reset_all_ready_q");
        expect_at(m, F_ALL, -1, 1, "pre_reset_all");
        wait_cyc(m);
        resetn = 1'b0;
        wait_cyc(m + 1);
        resetn = 1'b1;
        expect_at(m + 1, F_RST, -1, 7, "midrst_rst");
        expect_at(m + 1, F_RDY, -1, 0, "midrst_rdy");
        expect_at(m + 1, F_ALL, -1, 0, "midrst_all");
        expect_at(m + 1, F_CNT, -1, 0, "midrst_cnt");
        expect_at(m + 8, F_RST, -1, 7, "midrst_rst_hold");
        expect_at(m + 9, F_RST, -1, 0, "midrst_rst_rel");
        expect_at(m + 25, F_RDY, -1, 0, "midrst_ready_early");
        expect_at(m + 26, F_RDY, -1, 7, "midrst_ready");
        wait_cyc(m + 30);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        foreach (exp_q[i]) begin
            errors++;
            $display("FAIL %s never compared (due %0d) got=none expected=%0d",
                     exp_q[i].name, exp_q[i].cyc, exp_q[i].val);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
